// File: rtl/mux_rr_arbiter_pkg.sv
// Shared constants, FSM state type and helpers for the round-robin 8:1 mux arbiter.
package mux_arb_pkg;

  localparam int NREQ  = 8;  // number of requesters / mux inputs
  localparam int SEL_W = 3;  // width of the mux select and round-robin pointer
  localparam int TEN_W = 4;  // width of the tenure counter (MAX_HOLD up to 15)

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  // One-hot encoding of a requester index.
  function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Request/grant bundle between the requesters and the arbiter driving the 8:1 mux.
interface mux_rr_arbiter_if;
  import mux_arb_pkg::*;

  logic [NREQ-1:0]  REQ;
  logic [NREQ-1:0]  GNT;
  logic [SEL_W-1:0] S;
  logic             BUSY;
  logic [TEN_W-1:0] TENURE;

  // Arbiter side: samples requests, drives grant, select and status.
  modport master (
    input  REQ,
    output GNT,
    output S,
    output BUSY,
    output TENURE
  );

  // Requester side: drives requests, observes grant and status.
  modport slave (
    output REQ,
    input  GNT,
    input  S,
    input  BUSY,
    input  TENURE
  );

endinterface

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Rotating-priority search: first requester at or after ptr (mod 8) that is asserting.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] winner,
  output logic             found
);

  // rot[k] is the request of index (ptr + k) mod 8, so bit 0 has highest priority.
  logic [NREQ-1:0]  rot;
  logic [SEL_W-1:0] offset;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
    logic [SEL_W-1:0] idx;
    assign idx     = ptr + SEL_W'(gi);
    assign rot[gi] = req[idx];
  end

  // Lowest set bit of the rotated vector; scanning downward lets the lowest win.
  always_comb begin
    offset = '0;
    found  = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        offset = SEL_W'(k);
        found  = 1'b1;
      end
    end
  end

  assign winner = ptr + offset;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning an 8:1 mux select, with a per-grant hold limit.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4  // legal 1..15
) (
  input  logic             CLK,
  input  logic             RST,
  mux_rr_arbiter_if.master arb
);

  arb_state_e       state_reg;
  logic [NREQ-1:0]  gnt_reg;
  logic [SEL_W-1:0] s_reg;
  logic             busy_reg;
  logic [TEN_W-1:0] tenure_reg;
  logic [SEL_W-1:0] ptr_reg;

  logic [SEL_W-1:0] win;
  logic             found;
  logic             release_now;

  rr_pick u_pick (
    .req    (arb.REQ),
    .ptr    (ptr_reg),
    .winner (win),
    .found  (found)
  );

  // Owner gives up the mux when it drops its request or hits the hold limit.
  assign release_now = (state_reg == OWN) &&
                       (!arb.REQ[s_reg] || (tenure_reg == TEN_W'(MAX_HOLD - 1)));

  // Arbitration FSM; every output is a register so REQ never reaches an output combinationally.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg  <= IDLE;
      gnt_reg    <= '0;
      s_reg      <= '0;
      busy_reg   <= 1'b0;
      tenure_reg <= '0;
      ptr_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          // S and PTR hold while nobody asks, so S keeps the last owner.
          if (found) begin
            state_reg  <= OWN;
            gnt_reg    <= onehot(win);
            s_reg      <= win;
            busy_reg   <= 1'b1;
            tenure_reg <= '0;
            ptr_reg    <= win + SEL_W'(1);
          end
        end
        OWN: begin
          if (release_now) begin
            // Re-arbitrate in the same edge so a waiting requester sees no idle bubble;
            // the old owner sits last in line because PTR already points past it.
            if (found) begin
              gnt_reg    <= onehot(win);
              s_reg      <= win;
              busy_reg   <= 1'b1;
              tenure_reg <= '0;
              ptr_reg    <= win + SEL_W'(1);
            end else begin
              state_reg  <= IDLE;
              gnt_reg    <= '0;
              busy_reg   <= 1'b0;
              tenure_reg <= '0;
            end
          end else begin
            tenure_reg <= tenure_reg + TEN_W'(1);
          end
        end
        default: begin
          state_reg  <= IDLE;
          gnt_reg    <= '0;
          busy_reg   <= 1'b0;
          tenure_reg <= '0;
        end
      endcase
    end
  end

  assign arb.GNT    = gnt_reg;
  assign arb.S      = s_reg;
  assign arb.BUSY   = busy_reg;
  assign arb.TENURE = tenure_reg;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed and randomized checks of the round-robin mux arbiter (MAX_HOLD=4 and MAX_HOLD=1).
module tb_mux_rr_arbiter;
  import mux_arb_pkg::*;

  logic CLK;
  logic RST;
  int   n_cmp;
  int   n_bad;

  mux_rr_arbiter_if if4 ();
  mux_rr_arbiter_if if1 ();

  mux_rr_arbiter #(.MAX_HOLD(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .arb (if4.master)
  );

  mux_rr_arbiter #(.MAX_HOLD(1)) dut1 (
    .CLK (CLK),
    .RST (RST),
    .arb (if1.master)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check4(input string tag, input logic [7:0] g, input logic [2:0] s,
                        input logic b, input logic [3:0] t);
    check({tag, ".GNT"}, 32'(if4.GNT), 32'(g));
    check({tag, ".S"}, 32'(if4.S), 32'(s));
    check({tag, ".BUSY"}, 32'(if4.BUSY), 32'(b));
    check({tag, ".TENURE"}, 32'(if4.TENURE), 32'(t));
  endtask

  logic [7:0] rq;
  int         wait_cnt [8];
  logic [7:0] g_prev;

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    RST     = 1'b1;
    if4.REQ = '0;
    if1.REQ = '0;

    // Reset state
    step();
    check4("reset", 8'h00, 3'd0, 1'b0, 4'd0);
    check("reset1.GNT", 32'(if1.GNT), 32'h0);

    // Single requester 2 held: grant after 1 cycle, tenure 0..3, then re-grant
    RST     = 1'b0;
    if4.REQ = 8'h04;
    check4("idle_before_grant", 8'h00, 3'd0, 1'b0, 4'd0);
    for (int t = 0; t < 4; t++) begin
      step();
      check4($sformatf("single_t%0d", t), 8'h04, 3'd2, 1'b1, 4'(t));
    end
    step();
    check4("single_regrant", 8'h04, 3'd2, 1'b1, 4'd0);

    // All requesting: rotation 0..7,0 each held exactly 4 cycles
    RST = 1'b1;
    step();
    RST     = 1'b0;
    if4.REQ = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      for (int t = 0; t < 4; t++) begin
        step();
        check4($sformatf("all_i%0d_t%0d", i, t), 8'(1 << (i % 8)), 3'(i % 8), 1'b1, 4'(t));
      end
    end

    // Early drop: requester 0 leaves, 4 takes over without an idle cycle
    RST = 1'b1;
    step();
    RST     = 1'b0;
    if4.REQ = 8'h11;
    step();
    check4("drop_own0", 8'h01, 3'd0, 1'b1, 4'd0);
    step();
    check4("drop_own1", 8'h01, 3'd0, 1'b1, 4'd1);
    if4.REQ = 8'h10;
    #1;
    check4("drop_gnt_still_high", 8'h01, 3'd0, 1'b1, 4'd1);
    step();
    check4("drop_handover", 8'h10, 3'd4, 1'b1, 4'd0);
    if4.REQ = 8'h00;
    step();
    check4("drop_idle", 8'h00, 3'd4, 1'b0, 4'd0);
    step();
    check4("drop_idle_hold", 8'h00, 3'd4, 1'b0, 4'd0);

    // MAX_HOLD=1: grant alternates every cycle between 0 and 7
    if1.REQ = 8'h81;
    for (int c = 0; c < 6; c++) begin
      step();
      check($sformatf("mh1_c%0d.GNT", c), 32'(if1.GNT), (c % 2 == 0) ? 32'h01 : 32'h80);
      check($sformatf("mh1_c%0d.S", c), 32'(if1.S), (c % 2 == 0) ? 32'd0 : 32'd7);
    end
    if1.REQ = 8'h00;

    // Reset mid-ownership, then first arbitration favours index 0
    if4.REQ = 8'h20;
    step();
    check4("rst_mid_own", 8'h20, 3'd5, 1'b1, 4'd0);
    step();
    check4("rst_mid_own1", 8'h20, 3'd5, 1'b1, 4'd1);
    RST = 1'b1;
    step();
    check4("rst_dropped", 8'h00, 3'd0, 1'b0, 4'd0);
    RST     = 1'b0;
    if4.REQ = 8'h21;
    step();
    check4("post_rst_first", 8'h01, 3'd0, 1'b1, 4'd0);
    step();
    step();
    step();
    check4("post_rst_t3", 8'h01, 3'd0, 1'b1, 4'd3);
    step();
    check4("post_rst_next", 8'h20, 3'd5, 1'b1, 4'd0);

    // Random traffic: one-hot grant, S/GNT agreement and wait bound
    RST = 1'b1;
    step();
    RST     = 1'b0;
    if4.REQ = '0;
    rq      = '0;
    for (int i = 0; i < 8; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      step();
      g_prev = if4.GNT;
      check("rand_onehot", 32'($countones(g_prev) <= 1), 32'd1);
      check("rand_busy", 32'(if4.BUSY), 32'(g_prev != 8'h00));
      if (if4.BUSY) check("rand_s_match", 32'(g_prev), 32'(onehot(if4.S)));
      for (int i = 0; i < 8; i++) begin
        if (g_prev[i]) begin
          if (rq[i] && $urandom_range(3) == 0) rq[i] = 1'b0;
        end else if (!rq[i]) begin
          if ($urandom_range(2) == 0) rq[i] = 1'b1;
        end
      end
      if4.REQ = rq;
      for (int i = 0; i < 8; i++) begin
        if (g_prev[i]) wait_cnt[i] = 0;
        else if (rq[i]) wait_cnt[i]++;
        else wait_cnt[i] = 0;
        if (wait_cnt[i] > 7 * 4) begin
          check($sformatf("rand_wait_bound_%0d", i), 32'(wait_cnt[i]), 32'(7 * 4));
          wait_cnt[i] = 0;
        end
      end
    end
    check("rand_ran", 32'(n_cmp > 9000), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
